// File: rtl/dcsk_rx_frame_ctrl_if.sv
// Payload stream from the frame controller to the downstream consumer.
// Valid/ready handshake; the word and its last flag travel together.
interface dcsk_rx_frame_ctrl_if;
    logic [31:0] Out_Word;
    logic        Out_Last;
    logic        Out_Valid;
    logic        Out_Ready;

    modport master (
        output Out_Word,
        output Out_Last,
        output Out_Valid,
        input  Out_Ready
    );

    modport slave (
        input  Out_Word,
        input  Out_Last,
        input  Out_Valid,
        output Out_Ready
    );
endinterface

// File: rtl/dcsk_rx_frame_ctrl.sv
// DCSK receive frame controller: chip gating, spread-factor config with flush,
// sync hunt, length header parse and a small payload FIFO.
module dcsk_rx_frame_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int FLUSH_CYC   = 2
) (
    input  logic                  Clk,
    input  logic                  N_Rst,
    input  logic                  En,
    input  logic                  Chip_Valid,
    input  logic [1:0]            Cfg_Spread_Factor_Sel,
    input  logic [31:0]           Cfg_Sync_Word,
    input  logic                  Cfg_Update,
    output logic                  Demod_Valid,
    output logic [1:0]            Demod_Spread_Factor_Sel,
    output logic                  Demod_Rst_N,
    input  logic [31:0]           Demod_Out_Data,
    input  logic                  Demod_Valid_Data,
    dcsk_rx_frame_ctrl_if.master  Out_If,
    output logic                  Frame_Start,
    output logic                  Frame_Err,
    output logic                  Overflow,
    output logic                  Busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int FW = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {IDLE, HUNT, HEADER, PAYLOAD} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [7:0]   r_rem;
    logic [TW-1:0] r_tmo;
    logic [FW-1:0] r_flush_cnt;
    logic         r_demod_rst_n;
    logic [1:0]   r_sel;
    logic [1:0]   r_pend_sel;
    logic         r_pend;
    logic         r_start;
    logic         r_err;
    logic         r_ovf;
    logic [32:0]  r_mem [FIFO_DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;

    logic       w_dv;
    logic       w_busy;
    logic       w_tmo;
    logic       w_start;
    logic       w_err;
    logic       w_enter_hunt;
    logic       w_new_pend;
    logic [1:0] w_new_sel;
    logic       w_apply;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_push_req;
    logic       w_push;
    logic       w_drop;

    // Words arriving while the demodulator is held in flush are garbage.
    assign w_dv   = Demod_Valid_Data & r_demod_rst_n;
    assign w_busy = (r_state == HEADER) || (r_state == PAYLOAD);
    assign w_tmo  = w_busy & ~w_dv & (r_tmo == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_err   = 1'b0;
        if (!En) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_demod_rst_n) w_next = HUNT;
                end
                HUNT: begin
                    if (w_dv && Demod_Out_Data == Cfg_Sync_Word)
                        w_next = HEADER;
                end
                HEADER: begin
                    if (w_dv) begin
                        if (Demod_Out_Data[7:0] == 8'd0) begin
                            w_err  = 1'b1;
                            w_next = HUNT;
                        end else begin
                            w_start = 1'b1;
                            w_next  = PAYLOAD;
                        end
                    end else if (w_tmo) begin
                        w_err  = 1'b1;
                        w_next = HUNT;
                    end
                end
                PAYLOAD: begin
                    if (w_dv) begin
                        if (r_rem == 8'd1) w_next = HUNT;
                    end else if (w_tmo) begin
                        w_err  = 1'b1;
                        w_next = HUNT;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // A config request in mid-frame waits for the next HUNT entry.
    assign w_enter_hunt = (w_next == HUNT) && (r_state != HUNT);
    assign w_new_pend   = Cfg_Update | r_pend;
    assign w_new_sel    = Cfg_Update ? Cfg_Spread_Factor_Sel : r_pend_sel;
    assign w_apply      = (Cfg_Update & ~w_busy) | (w_new_pend & w_enter_hunt);

    assign w_empty    = (r_wr == r_rd);
    assign w_full     = (r_wr[AW] != r_rd[AW]) &&
                        (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop      = ~w_empty & Out_If.Out_Ready;
    assign w_push_req = (r_state == PAYLOAD) & w_dv;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_ff @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            r_state       <= IDLE;
            r_rem         <= '0;
            r_tmo         <= '0;
            r_flush_cnt   <= FW'(FLUSH_CYC);
            r_demod_rst_n <= 1'b0;
            r_sel         <= 2'b00;
            r_pend_sel    <= 2'b00;
            r_pend        <= 1'b0;
            r_start       <= 1'b0;
            r_err         <= 1'b0;
            r_ovf         <= 1'b0;
            r_wr          <= '0;
            r_rd          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_next;
            r_start <= w_start;
            r_err   <= w_err;

            if (r_state == HEADER && w_dv)
                r_rem <= Demod_Out_Data[7:0];
            else if (w_push_req)
                r_rem <= r_rem - 8'd1;

            if (!w_busy || w_dv)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + TW'(1);

            if (w_apply) begin
                r_sel  <= w_new_sel;
                r_pend <= 1'b0;
            end else if (Cfg_Update) begin
                r_pend_sel <= Cfg_Spread_Factor_Sel;
                r_pend     <= 1'b1;
            end

            if (w_apply) begin
                r_flush_cnt   <= FW'(FLUSH_CYC);
                r_demod_rst_n <= 1'b0;
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt   <= r_flush_cnt - FW'(1);
                r_demod_rst_n <= (r_flush_cnt == FW'(1));
            end else begin
                r_demod_rst_n <= 1'b1;
            end

            r_ovf <= (r_ovf & ~Cfg_Update) | w_drop;

            if (w_push) begin
                r_mem[r_wr[AW-1:0]] <= {(r_rem == 8'd1), Demod_Out_Data};
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
        end
    end

    assign Demod_Valid = Chip_Valid & En & r_demod_rst_n & (r_state != IDLE);
    assign Demod_Spread_Factor_Sel = r_sel;
    assign Demod_Rst_N = r_demod_rst_n;
    assign Out_If.Out_Word  = r_mem[r_rd[AW-1:0]][31:0];
    assign Out_If.Out_Last  = r_mem[r_rd[AW-1:0]][32];
    assign Out_If.Out_Valid = ~w_empty;
    assign Frame_Start = r_start;
    assign Frame_Err   = r_err;
    assign Overflow    = r_ovf;
    assign Busy        = w_busy;

endmodule

// File: tb/tb_dcsk_rx_frame_ctrl.sv
// Directed bench for dcsk_rx_frame_ctrl with hand-computed expectations.
module tb_dcsk_rx_frame_ctrl;

    logic        Clk = 1'b0;
    logic        N_Rst;
    logic        En;
    logic        Chip_Valid;
    logic [1:0]  Cfg_Spread_Factor_Sel;
    logic [31:0] Cfg_Sync_Word;
    logic        Cfg_Update;
    logic        Demod_Valid;
    logic [1:0]  Demod_Spread_Factor_Sel;
    logic        Demod_Rst_N;
    logic [31:0] Demod_Out_Data;
    logic        Demod_Valid_Data;
    logic        Frame_Start;
    logic        Frame_Err;
    logic        Overflow;
    logic        Busy;

    int n_tot = 0;
    int n_bad = 0;

    localparam logic [31:0] SYNC = 32'hA5A5_3C3C;

    dcsk_rx_frame_ctrl_if u_if ();

    dcsk_rx_frame_ctrl u_dut (
        .Clk                     (Clk),
        .N_Rst                   (N_Rst),
        .En                      (En),
        .Chip_Valid              (Chip_Valid),
        .Cfg_Spread_Factor_Sel   (Cfg_Spread_Factor_Sel),
        .Cfg_Sync_Word           (Cfg_Sync_Word),
        .Cfg_Update              (Cfg_Update),
        .Demod_Valid             (Demod_Valid),
        .Demod_Spread_Factor_Sel (Demod_Spread_Factor_Sel),
        .Demod_Rst_N             (Demod_Rst_N),
        .Demod_Out_Data          (Demod_Out_Data),
        .Demod_Valid_Data        (Demod_Valid_Data),
        .Out_If                  (u_if.master),
        .Frame_Start             (Frame_Start),
        .Frame_Err               (Frame_Err),
        .Overflow                (Overflow),
        .Busy                    (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        Demod_Out_Data   = d;
        Demod_Valid_Data = 1'b1;
        tick();
        Demod_Valid_Data = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] sel);
        Cfg_Spread_Factor_Sel = sel;
        Cfg_Update = 1'b1;
        tick();
        Cfg_Update = 1'b0;
    endtask

    initial begin
        N_Rst = 1'b1;
        En = 1'b0;
        Chip_Valid = 1'b0;
        Cfg_Spread_Factor_Sel = 2'b00;
        Cfg_Sync_Word = SYNC;
        Cfg_Update = 1'b0;
        Demod_Out_Data = '0;
        Demod_Valid_Data = 1'b0;
        u_if.Out_Ready = 1'b1;
        #3 N_Rst = 1'b0;
        repeat (3) tick();

        chk("rst_demod_rst_n", Demod_Rst_N, 0);
        chk("rst_out_valid", u_if.Out_Valid, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_sel", Demod_Spread_Factor_Sel, 0);
        chk("rst_ovf", Overflow, 0);

        // Flush release after reset
        N_Rst = 1'b1;
        #1 chk("rel_c0", Demod_Rst_N, 0);
        tick();
        chk("rel_c1", Demod_Rst_N, 0);
        tick();
        chk("rel_c2", Demod_Rst_N, 1);
        Chip_Valid = 1'b1;
        #1 chk("dv_en0", Demod_Valid, 0);
        En = 1'b1;
        tick();
        chk("dv_hunt", Demod_Valid, 1);

        // Non-sync word keeps hunting
        send(32'h1234_5678);
        chk("nosync_busy", Busy, 0);

        // Normal 3-word frame
        send(SYNC);
        chk("sync_busy", Busy, 1);
        send(32'h0000_0003);
        chk("f1_start", Frame_Start, 1);
        send(32'h11);
        chk("f1_start_pulse", Frame_Start, 0);
        chk("f1_w0", u_if.Out_Word, 32'h11);
        chk("f1_l0", u_if.Out_Last, 0);
        send(32'h22);
        chk("f1_w1", u_if.Out_Word, 32'h22);
        chk("f1_l1", u_if.Out_Last, 0);
        chk("f1_busy_mid", Busy, 1);
        send(32'h33);
        chk("f1_w2", u_if.Out_Word, 32'h33);
        chk("f1_l2", u_if.Out_Last, 1);
        chk("f1_busy_end", Busy, 0);
        tick();
        chk("f1_drained", u_if.Out_Valid, 0);

        // Zero-length header
        send(SYNC);
        send(32'h0000_0000);
        chk("z_err", Frame_Err, 1);
        chk("z_start", Frame_Start, 0);
        chk("z_busy", Busy, 0);
        chk("z_empty", u_if.Out_Valid, 0);
        tick();
        chk("z_err_pulse", Frame_Err, 0);

        // Overflow: 6 words into a 4-entry FIFO with no consumer
        u_if.Out_Ready = 1'b0;
        send(SYNC);
        send(32'h0000_0006);
        for (int i = 1; i <= 4; i++) send(32'(i));
        chk("ov_pre", Overflow, 0);
        send(32'h5);
        chk("ov_set", Overflow, 1);
        send(32'h6);
        chk("ov_busy", Busy, 0);
        chk("ov_hold_w", u_if.Out_Word, 32'h1);
        u_if.Out_Ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ov_w%0d", i), u_if.Out_Word, 64'(i));
            chk($sformatf("ov_l%0d", i), u_if.Out_Last, 0);
            tick();
        end
        chk("ov_drained", u_if.Out_Valid, 0);
        send(SYNC);
        send(32'h0000_0002);
        send(32'hAA);
        chk("ov2_l0", u_if.Out_Last, 0);
        send(32'hBB);
        chk("ov2_w1", u_if.Out_Word, 32'hBB);
        chk("ov2_l1", u_if.Out_Last, 1);
        cfg(2'b00);
        chk("ov_clr", Overflow, 0);
        chk("cfg_flush0", Demod_Rst_N, 0);
        tick();
        tick();
        chk("cfg_flush_done", Demod_Rst_N, 1);

        // Config change deferred to frame end
        send(SYNC);
        send(32'h0000_0002);
        send(32'h55);
        cfg(2'b10);
        chk("pend_sel", Demod_Spread_Factor_Sel, 0);
        chk("pend_rst_n", Demod_Rst_N, 1);
        send(32'h66);
        chk("pend_w", u_if.Out_Word, 32'h66);
        chk("pend_l", u_if.Out_Last, 1);
        chk("pend_applied", Demod_Spread_Factor_Sel, 2'b10);
        chk("pend_fl0", Demod_Rst_N, 0);
        tick();
        chk("pend_fl1", Demod_Rst_N, 0);
        chk("pend_dv_gated", Demod_Valid, 0);
        tick();
        chk("pend_fl2", Demod_Rst_N, 1);

        // Timeout after 2 of 5 payload words
        u_if.Out_Ready = 1'b0;
        send(SYNC);
        send(32'h0000_0005);
        send(32'h71);
        send(32'h72);
        repeat (4095) tick();
        chk("to_busy_before", Busy, 1);
        chk("to_err_before", Frame_Err, 0);
        tick();
        chk("to_err", Frame_Err, 1);
        chk("to_busy", Busy, 0);
        chk("to_w0", u_if.Out_Word, 32'h71);
        chk("to_l0", u_if.Out_Last, 0);
        u_if.Out_Ready = 1'b1;
        tick();
        chk("to_w1", u_if.Out_Word, 32'h72);
        chk("to_l1", u_if.Out_Last, 0);
        tick();
        chk("to_drained", u_if.Out_Valid, 0);
        send(SYNC);
        chk("to_hunt", Busy, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/dcsk_rx_frame_ctrl.md
Name: dcsk_rx_frame_ctrl

Overview:
- Frame-level controller that sits between the chip input and the DCSK demodulator top, and between the demodulator's 32-bit word output and the downstream consumer.
- Gates chip Valid, owns spread-factor configuration, and flushes the demodulator on configuration change.
- Hunts for a 32-bit sync word, parses a length header, and counts payload words.
- Buffers payload in a small FIFO with valid/ready output, because the demodulator cannot be back-pressured.

Parameters:
FIFO_DEPTH, 4, payload FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 4096, max cycles between demod words inside a frame before abort
FLUSH_CYC, 2, cycles Demod_Rst_N is held low on flush

Ports:
Clk  in  1  clock
N_Rst  in  1  asynchronous active-low reset
En  in  1  block enable; low forces IDLE
Chip_Valid  in  1  upstream chip-valid strobe
Cfg_Spread_Factor_Sel  in  2  requested spread factor select
Cfg_Sync_Word  in  32  frame sync pattern
Cfg_Update  in  1  1-cycle pulse: request config apply, clear Overflow
Demod_Valid  out  1  Valid to demodulator
Demod_Spread_Factor_Sel  out  2  applied spread factor select
Demod_Rst_N  out  1  registered active-low demodulator flush/reset
Demod_Out_Data  in  32  demodulated word
Demod_Valid_Data  in  1  1-cycle strobe qualifying Demod_Out_Data
Out_Word  out  32  payload word (FIFO head)
Out_Last  out  1  marks last payload word of frame
Out_Valid  out  1  FIFO non-empty
Out_Ready  in  1  consumer accepts head when high with Out_Valid
Frame_Start  out  1  1-cycle pulse on valid header
Frame_Err  out  1  1-cycle pulse on zero length or timeout
Overflow  out  1  sticky: payload word dropped on full FIFO
Busy  out  1  state is HEADER or PAYLOAD

Behaviour:
- Reset values:
  - state = IDLE; all outputs 0 except Demod_Spread_Factor_Sel = 2'b00.
  - Demod_Rst_N = 0; it releases to 1 FLUSH_CYC cycles after N_Rst deasserts.
  - FIFO empty; timeout counter 0; pending-config flag 0.
- Demod_Valid = Chip_Valid & En & Demod_Rst_N & (state != IDLE). Combinational: it is a pure gate, so no chip is lost or delayed.
- States:
  - IDLE -> HUNT when En = 1 and no flush is in progress.
  - HUNT: a word with Demod_Valid_Data = 1 and Demod_Out_Data == Cfg_Sync_Word -> HEADER; otherwise stay.
  - HEADER: next strobed word is the header; len = word[7:0].
    - len == 0 -> Frame_Err pulse, -> HUNT.
    - Else load remaining = len, pulse Frame_Start, -> PAYLOAD.
  - PAYLOAD: each strobed word is pushed with Out_Last = (remaining == 1); remaining decrements. Pushing the word with remaining == 1 -> HUNT.
  - En low in any state -> IDLE next cycle. The FIFO is kept and drains normally.
- Timeout:
  - Counter runs in HEADER/PAYLOAD; it clears on every Demod_Valid_Data.
  - Reaching TIMEOUT_CYC -> Frame_Err pulse, -> HUNT.
  - Words already buffered stay in the FIFO. No synthetic Out_Last is generated.
- Config:
  - Cfg_Update in IDLE/HUNT applies immediately: Demod_Spread_Factor_Sel takes Cfg_Spread_Factor_Sel, and Demod_Rst_N is held low FLUSH_CYC cycles starting the next cycle; state returns to HUNT.
  - Cfg_Update in HEADER/PAYLOAD latches the value and sets pending. The update applies, with flush, on the cycle the FSM enters HUNT.
  - A second update while pending overwrites the latched value.
  - Cfg_Sync_Word is sampled combinationally; software changes it only while Busy = 0.
  - Cfg_Update clears Overflow in any state.
- Demod words are ignored while Demod_Rst_N = 0.
- FIFO:
  - 33 bits wide ({Out_Last, word}); push latency 1, so Out_Valid is high the cycle after the strobe.
  - Pop when Out_Valid & Out_Ready.
  - Push and pop in the same cycle at full is allowed and succeeds.
  - Push at full without pop drops the word and sets Overflow. Remaining and Out_Last bookkeeping still advance, so the frame boundary stays correct.
  - Out_Word/Out_Last are stable while Out_Valid = 1 and Out_Ready = 0.
- Async reset mid-frame clears everything immediately, including FIFO contents.

Test Plan:
- Reset with N_Rst held, then release -> Demod_Rst_N = 0 for exactly 2 cycles, then 1; Demod_Valid stays 0 until En = 1.
- Sync 0xA5A5_3C3C, header 0x0000_0003, payload 0x11, 0x22, 0x33, Out_Ready = 1 -> Frame_Start 1 cycle after header strobe; three words out, Out_Last only on 0x33; Busy falls after the 0x33 push.
- Header 0x0000_0000 -> Frame_Err pulse, state HUNT, no Frame_Start, FIFO empty.
- Out_Ready = 0, frame of 6 words, FIFO_DEPTH = 4 -> 4 words held, Overflow = 1; a later frame's Out_Last position is still correct; Cfg_Update clears Overflow.
- Cfg_Update with Sel = 2'b10 during PAYLOAD -> Demod_Spread_Factor_Sel unchanged until frame end, then changes on the HUNT entry with a 2-cycle Demod_Rst_N low.
- Frame header len = 5, demod stops after 2 words -> Frame_Err at 4096 idle cycles, return to HUNT, 2 words remain in FIFO with Out_Last = 0.
